// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by decode, writeback and the register file.
package cpu_pkg;

  localparam int NREGS  = 16;
  localparam int AWIDTH = 4;
  localparam int DWIDTH = 32;

  typedef logic [AWIDTH-1:0] reg_index_t;
  typedef logic [DWIDTH-1:0] reg_data_t;

  localparam reg_index_t REG_FP = 4'd0;
  localparam reg_index_t REG_SP = 4'd1;
  localparam reg_index_t REG_R0 = 4'd2;

endpackage

// File: rtl/cpu_scoreboard.sv
// Per-register pending-write counters feeding the decode RAW-hazard stall.
module cpu_scoreboard #(
  parameter int NREGS  = cpu_pkg::NREGS,
  parameter int AWIDTH = cpu_pkg::AWIDTH,
  parameter int PWIDTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reserve_enable_i,
  input  logic [AWIDTH-1:0] reserve_index_i,
  input  logic              write_enable_i,
  input  logic [AWIDTH-1:0] write_index_i,
  input  logic [AWIDTH-1:0] reg0_index_i,
  input  logic [AWIDTH-1:0] reg1_index_i,
  output logic              hazard_o,
  output logic              overflow_o
);

  localparam logic [PWIDTH-1:0] CNT_MAX = '1;

  logic [PWIDTH-1:0] cnt     [NREGS];
  logic [PWIDTH-1:0] cnt_nxt [NREGS];
  logic              ovf_set;

  always_comb begin
    ovf_set = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt[i] = cnt[i];
      // A reservation and a write to the same index cancel out.
      if (reserve_enable_i && (reserve_index_i == AWIDTH'(i)) &&
          !(write_enable_i && (write_index_i == AWIDTH'(i)))) begin
        if (cnt[i] == CNT_MAX) ovf_set = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (write_enable_i && (write_index_i == AWIDTH'(i)) &&
                   !(reserve_enable_i && (reserve_index_i == AWIDTH'(i)))) begin
        if (cnt[i] != '0) cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      overflow_o <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= cnt_nxt[i];
      if (ovf_set) overflow_o <= 1'b1;
    end
  end

  // Registered counts only: a write landing this cycle clears the stall next cycle.
  assign hazard_o = (cnt[reg0_index_i] != '0) | (cnt[reg1_index_i] != '0);

endmodule

// File: rtl/cpu_registerfile.sv
// Architectural register file: writeback sink, two registered read ports with bypass, hazard scoreboard.
module cpu_registerfile #(
  parameter int NREGS  = cpu_pkg::NREGS,
  parameter int AWIDTH = cpu_pkg::AWIDTH,
  parameter int DWIDTH = cpu_pkg::DWIDTH,
  parameter int PWIDTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AWIDTH-1:0] register_write_index_i,
  input  logic              register_write_enable_i,
  input  logic [DWIDTH-1:0] result_i,
  input  logic [AWIDTH-1:0] reg0_index_i,
  input  logic [AWIDTH-1:0] reg1_index_i,
  output logic [DWIDTH-1:0] value0_o,
  output logic [DWIDTH-1:0] value1_o,
  input  logic              reserve_enable_i,
  input  logic [AWIDTH-1:0] reserve_index_i,
  output logic              hazard_o,
  output logic              overflow_o
);

  logic [DWIDTH-1:0] rf [NREGS];
  logic              byp0;
  logic              byp1;

  assign byp0 = register_write_enable_i && (register_write_index_i == reg0_index_i);
  assign byp1 = register_write_enable_i && (register_write_index_i == reg1_index_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (register_write_enable_i) begin
      rf[register_write_index_i] <= result_i;
    end
  end

  // Same-cycle write is forwarded so decode never sees stale data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      value0_o <= '0;
      value1_o <= '0;
    end else begin
      value0_o <= byp0 ? result_i : rf[reg0_index_i];
      value1_o <= byp1 ? result_i : rf[reg1_index_i];
    end
  end

  cpu_scoreboard #(
    .NREGS  (NREGS),
    .AWIDTH (AWIDTH),
    .PWIDTH (PWIDTH)
  ) u_scoreboard (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .reserve_enable_i (reserve_enable_i),
    .reserve_index_i  (reserve_index_i),
    .write_enable_i   (register_write_enable_i),
    .write_index_i    (register_write_index_i),
    .reg0_index_i     (reg0_index_i),
    .reg1_index_i     (reg1_index_i),
    .hazard_o         (hazard_o),
    .overflow_o       (overflow_o)
  );

endmodule

// File: doc/cpu_registerfile.md
Name: cpu_registerfile

Overview:
- Architectural register file at the consumer end of the writeback interface.
- Accepts the registered write stream (index/enable/result) from the writeback stage and serves two synchronous read ports to decode.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Holds 16 x 32-bit moxie registers ($fp, $sp, $r0..$r13 at indices 0..15).

Parameters:
NREGS, 16, number of registers; must be a power of two
AWIDTH, 4, register index width, log2(NREGS)
DWIDTH, 32, register data width
PWIDTH, 2, pending-counter width per register; saturates at 2^PWIDTH-1

Ports:
clk_i  input  1  clock; all state updates on its rising edge
rst_i  input  1  asynchronous, active-low reset
register_write_index_i  input  4  writeback destination index
register_write_enable_i  input  1  writeback valid
result_i  input  32  writeback data
reg0_index_i  input  4  read port 0 index
reg1_index_i  input  4  read port 1 index
value0_o  output  32  read port 0 data, registered
value1_o  output  32  read port 1 data, registered
reserve_enable_i  input  1  decode issues an instruction that will write reserve_index_i
reserve_index_i  input  4  destination being reserved
hazard_o  output  1  combinational; pending count of reg0_index_i or reg1_index_i is nonzero
overflow_o  output  1  sticky; a reservation hit a saturated counter

Behaviour:
- Reset (rst_i low, asynchronous assert, synchronous release):
  - All registers = 0.
  - All pending counters = 0.
  - value0_o = value1_o = 0.
  - overflow_o = 0.
  - hazard_o therefore reads 0.
- Write:
  - When register_write_enable_i = 1 at a rising edge, rf[register_write_index_i] <= result_i.
  - When enable = 0, nothing is written.
- Read:
  - Latency is 1 cycle: valueN_o <= rf[regN_index_i] at each rising edge.
  - Write-through bypass: if the write is enabled and register_write_index_i == regN_index_i in the same cycle, valueN_o <= result_i (new data, not stale).
  - Both ports may name the same index; both outputs carry identical data.
- Scoreboard: each register has a PWIDTH-bit pending counter. Per edge, per index i:
  - Reserve only (reserve_enable_i and reserve_index_i == i): count + 1.
  - Write only (register_write_enable_i and register_write_index_i == i): count - 1.
  - Reserve and write to the same index in the same cycle: count unchanged.
  - Reserve at saturation (count = 3), with no same-cycle write to that index: count stays 3 and overflow_o <= 1. overflow_o stays 1 until reset.
  - Write at count 0 (unreserved write): count stays 0. This is legal and raises no flag.
- hazard_o:
  - Combinational from registered counters only: (cnt[reg0_index_i] != 0) | (cnt[reg1_index_i] != 0).
  - A write landing this cycle does not clear hazard_o until the next cycle.
  - Decode re-samples one cycle later and receives bypassed data.
- Reset asserted mid-operation:
  - All state clears immediately.
  - Writes or reservations presented in that cycle are dropped.

Decomposition:
- Shared package (cpu_pkg), consumed by decode, writeback and this block:
  - AWIDTH, DWIDTH and NREGS constants.
  - Named register indices REG_FP = 0, REG_SP = 1, REG_R0 = 2.
  - reg_index_t typedef.
- One natural sub-module: cpu_scoreboard, holding the pending counters, the hazard logic and overflow_o.
- Storage array and read bypass stay in cpu_registerfile.

Test Plan:
1. Reset, then read indices 0 and 15 -> value0_o = value1_o = 0, hazard_o = 0, overflow_o = 0.
2. Write idx 3 = 0xDEADBEEF; next cycle read port 0 idx 3 -> value0_o = 0xDEADBEEF one cycle after the index is applied.
3. Same-cycle write idx 5 = 0x12345678 and read both ports idx 5 -> value0_o = value1_o = 0x12345678 at the next edge (bypass).
4. Scoreboard sequence:
   - Reserve idx 7 twice; reg0_index_i = 7 -> hazard_o = 1.
   - One write to idx 7 -> hazard_o still 1.
   - Second write to idx 7 -> hazard_o = 0 the following cycle.
   - Simultaneous reserve and write to idx 7 -> count unchanged.
5. Reserve idx 2 four times with no writes -> count saturates at 3 and overflow_o = 1. Three writes to idx 2 -> hazard_o = 0; overflow_o remains 1.
6. Reserve idx 9, then assert rst_i low mid-cycle -> outputs and counters clear asynchronously, hazard_o = 0. After release, a read of idx 9 returns 0.
